atb_funnel_n: RTL and testbench
===============================

# atb_funnel_n

Parametrised N-port CoreSight ATB trace funnel for the debug subsystem. It replaces the fixed six-master trace matrix and sits between the ETM/ITM/STM trace sources and the trace buffer/TPIU. It adds:

- a per-port enable mask
- selectable fixed-priority or round-robin arbitration
- packet-locked grants with a bounded hold length
- a flush handshake
- a registered 2-entry output skid buffer

## Interface

Parameters:
- NUM_PORTS, 6, number of ATB slave ports (2..16)
- DATA_WIDTH, 64, ATB data width
- ATID_WIDTH, 8, trace ID width
- MAX_HOLD, 16, maximum beats per grant; 0 means unlimited (release on atlast only)

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  funnel clock
- rst_i  in  1  asynchronous active-high reset
- s_atid_i  in  NUM_PORTS×ATID_WIDTH  per-port trace ID
- s_atvalid_i  in  NUM_PORTS  per-port beat valid
- s_atdata_i  in  NUM_PORTS×DATA_WIDTH  per-port data
- s_atlast_i  in  NUM_PORTS  last beat of packet
- s_atready_o  out  NUM_PORTS  per-port ready
- m_atid_o  out  ATID_WIDTH  funnelled ID
- m_atvalid_o  out  1  output valid
- m_atdata_o  out  DATA_WIDTH  output data
- m_atlast_o  out  1  output last
- m_atready_i  in  1  downstream ready
- port_en_i  in  NUM_PORTS  port enable mask
- rr_mode_i  in  1  0 = fixed priority (port 0 highest), 1 = round robin
- flush_req_i  in  1  level flush request
- flush_done_o  out  1  flush complete
- grant_o  out  NUM_PORTS  one-hot current owner (0 when idle)

## Operation

Arbiter FSM has two states, ARB and LOCKED.

ARB state:
- Candidates are ports with s_atvalid_i & port_en_i.
- Fixed mode: the lowest index wins.
- RR mode: the search starts at last_owner+1 modulo NUM_PORTS; last_owner resets to NUM_PORTS-1.
- On a winner, grant is registered; LOCKED and grant_o take effect the next cycle.

LOCKED state:
- The owner port's beats pass to the skid buffer.
- Beat counter: width $clog2(MAX_HOLD+1), cleared on grant, incremented per accepted beat.

Release from LOCKED back to ARB, effective the next cycle, occurs on any of:
- an accepted beat with atlast = 1;
- the accepted-beat count reaching MAX_HOLD (when MAX_HOLD ≠ 0);
- the owner's port_en_i deasserting, which truncates the packet; no atlast is synthesised.

Release behaviour:
- last_owner updates on release.
- There is exactly one ARB cycle between consecutive grants.

Per-port ready and enable rules:
- s_atready_o[i] = grant_o[i] & port_en_i[i] & ~skid_full. It never depends combinationally on m_atready_i.
- Disabled or ungranted ports see atready = 0; their valid/data are ignored and must be held by the source.

Output path:
- The skid buffer stores {atid, data, last} and presents its head on m_*.
- It pops when m_atvalid_o & m_atready_i.
- A simultaneous push and pop on a full buffer is not allowed, because ready is already low when the buffer is full.

Flush:
- flush_done_o is registered and asserts when all of the following hold:
  - flush_req_i = 1;
  - the FSM is in ARB;
  - no enabled port has s_atvalid_i = 1;
  - the skid buffer is empty.
- It deasserts the cycle after flush_req_i falls or the condition breaks.
- Arbitration continues normally during a flush so that sources drain.

## Timing

- Reset values: s_atready_o = 0, m_atvalid_o = 0, m_atid_o/m_atdata_o/m_atlast_o = 0, grant_o = 0, flush_done_o = 0. FSM resets to ARB and the skid buffer is empty.
- Latency from request to first ready: valid at cycle N (ARB), grant_o and ready at N+1.
- Latency from accepted input beat to output: a beat accepted at cycle N appears on m_* at N+1.
- Sustained throughput is 1 beat/cycle while m_atready_i = 1. If m_atready_i stalls, at most 2 beats buffer and then ready drops the next cycle.
- Reset asserted mid-packet: all state clears immediately (asynchronous); any beats held in the buffer are lost.
- Changes to port_en_i and rr_mode_i are sampled every cycle. A mode change takes effect at the next ARB cycle.

## Structure

- Shared package atb_pkg holds:
  - ATB_ATID_W;
  - atb_beat_t, a packed struct {atid, data, last} parametrised through the package defaults;
  - arb_state_e {ARB, LOCKED}.
- Sub-module atb_skid_buf is a 2-entry registered FIFO with push/pop/full/empty, parametrised by payload width. It will be reused by the trace buffer input.

## Test plan

- Single-port stream: port 2 sends 5 beats, ID 0x12, last on beat 5, with m_atready_i = 1. Expect grant_o = 0b000100 from cycle 1, output beats at cycles 2..6 with matching data, then grant_o = 0.
- Fixed-priority contention: ports 1, 3 and 4 all request 2-beat packets with rr_mode_i = 0. Expect service order 1, 3, 4, with one ARB cycle between grants.
- Round-robin fairness: all 6 ports request continuously with rr_mode_i = 1. Expect grants in the order 0, 1, 2, 3, 4, 5, 0.
- MAX_HOLD = 4, port 0 sends a 10-beat packet while port 1 is pending. Expect port 0 released after 4 beats, port 1 served, then port 0 regranted.
- Backpressure: m_atready_i = 0 for 5 cycles mid-packet. Expect exactly 2 beats buffered, s_atready_o low, then no loss and no duplication after release.
- Flush with disable: port_en_i[0] drops mid-packet while flush_req_i = 1. Expect the packet truncated, grant_o = 0 the next cycle, and flush_done_o = 1 once the buffer drains and no enabled valid remains. Also check that asserting rst_i clears all outputs immediately.

Source files
------------

// File: rtl/atb_pkg.sv
// Shared ATB definitions: default widths, the beat payload record and arbiter states.
package atb_pkg;

  localparam int ATB_ATID_W = 8;
  localparam int ATB_DATA_W = 64;

  // One ATB beat as carried through the funnel output path.
  typedef struct packed {
    logic [ATB_ATID_W-1:0] atid;
    logic [ATB_DATA_W-1:0] data;
    logic                  last;
  } atb_beat_t;

  localparam int ATB_BEAT_W = $bits(atb_beat_t);

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/atb_skid_buf.sv
// Two-entry registered FIFO. The head entry is presented directly from storage,
// so a pushed word is visible on head_o the cycle after the push.
module atb_skid_buf #(
  parameter int WIDTH = 73
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  // Guard against overflow/underflow even if a caller misbehaves.
  assign push_ok = push_i & (count_q != 2'd2);
  assign pop_ok  = pop_i & (count_q != 2'd0);

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push_ok;
    rd_ptr_d = rd_ptr_q ^ pop_ok;
    count_d  = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  // Payload storage; cleared on reset so the outputs read zero while empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/atb_funnel_n.sv
// N-port ATB trace funnel: enable mask, fixed-priority or round-robin arbitration,
// packet-locked grants with optional hold limit, flush handshake, 2-entry output skid.
module atb_funnel_n
  import atb_pkg::*;
#(
  parameter int NUM_PORTS  = 6,
  parameter int DATA_WIDTH = ATB_DATA_W,
  parameter int ATID_WIDTH = ATB_ATID_W,
  parameter int MAX_HOLD   = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_PORTS*ATID_WIDTH-1:0]  s_atid_i,
  input  logic [NUM_PORTS-1:0]             s_atvalid_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_atdata_i,
  input  logic [NUM_PORTS-1:0]             s_atlast_i,
  output logic [NUM_PORTS-1:0]             s_atready_o,
  output logic [ATID_WIDTH-1:0]            m_atid_o,
  output logic                             m_atvalid_o,
  output logic [DATA_WIDTH-1:0]            m_atdata_o,
  output logic                             m_atlast_o,
  input  logic                             m_atready_i,
  input  logic [NUM_PORTS-1:0]             port_en_i,
  input  logic                             rr_mode_i,
  input  logic                             flush_req_i,
  output logic                             flush_done_o,
  output logic [NUM_PORTS-1:0]             grant_o
);

  localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  // A zero-width counter is illegal, so unlimited hold still keeps one bit.
  localparam int CNT_W  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int BEAT_W = ATID_WIDTH + DATA_WIDTH + 1;
  localparam bit HOLD_EN = (MAX_HOLD > 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  arb_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     last_owner_q, last_owner_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic                 flush_done_q, flush_done_d;

  logic [NUM_PORTS-1:0] cand;
  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic                 skid_full, skid_empty;
  logic                 owner_en, owner_last;
  logic                 accept, release_now;
  logic [BEAT_W-1:0]    push_beat, head_beat;

  assign cand = s_atvalid_i & port_en_i;

  // Ready is purely registered state plus the enable mask; never m_atready_i.
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ready
      assign s_atready_o[gi] = grant_q[gi] & port_en_i[gi] & ~skid_full;
    end
  endgenerate

  assign owner_en   = port_en_i[owner_q];
  assign owner_last = s_atlast_i[owner_q];
  assign accept     = |(s_atvalid_i & s_atready_o);
  assign push_beat  = {s_atid_i[owner_q*ATID_WIDTH +: ATID_WIDTH],
                       s_atdata_i[owner_q*DATA_WIDTH +: DATA_WIDTH],
                       owner_last};

  // Disabling the owner truncates the packet; otherwise release on last or hold limit.
  assign release_now = ~owner_en |
                       (accept & (owner_last | (HOLD_EN & (beat_cnt_q == HOLD_LAST))));

  // Winner selection: lowest index in fixed mode, rotating from last_owner+1 in RR mode.
  always_comb begin
    int j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    if (!rr_mode_i) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (cand[i]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(i);
        end
      end
    end else begin
      // Walk backwards so the nearest candidate after last_owner is assigned last.
      for (int k = NUM_PORTS; k >= 1; k--) begin
        j = (int'(last_owner_q) + k) % NUM_PORTS;
        if (cand[IDX_W'(j)]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(j);
        end
      end
    end
  end

  // Arbiter next-state: grant from ARB, count beats and release from LOCKED.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      ARB: begin
        if (win_found) begin
          state_d    = LOCKED;
          grant_d    = NUM_PORTS'(1) << win_idx;
          owner_d    = win_idx;
          beat_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
        if (release_now) begin
          state_d      = ARB;
          grant_d      = '0;
          last_owner_d = owner_q;
        end
      end
      default: begin
        state_d = ARB;
        grant_d = '0;
      end
    endcase
  end

  // Flush completes only when nothing is in flight anywhere in the funnel.
  always_comb begin
    flush_done_d = flush_req_i & (state_q == ARB) & ~(|cand) & skid_empty;
  end

  // Arbiter and flush registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ARB;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(NUM_PORTS - 1);
      beat_cnt_q   <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      flush_done_q <= flush_done_d;
    end
  end

  atb_skid_buf #(
    .WIDTH (BEAT_W)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (accept),
    .push_data_i (push_beat),
    .pop_i       (m_atvalid_o & m_atready_i),
    .head_o      (head_beat),
    .full_o      (skid_full),
    .empty_o     (skid_empty)
  );

  assign m_atvalid_o = ~skid_empty;
  assign {m_atid_o, m_atdata_o, m_atlast_o} = head_beat;
  assign grant_o      = grant_q;
  assign flush_done_o = flush_done_q;

endmodule

// File: tb/tb_atb_funnel_n.sv
// Directed bench for atb_funnel_n: a table-driven single-port stream plus
// hand-written sequences for contention, RR, hold limit, backpressure, flush and reset.
`timescale 1ns/1ps
module tb_atb_funnel_n;

  localparam int NP = 6;
  localparam int DW = 64;
  localparam int IW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NP*IW-1:0] s_atid;
  logic [NP-1:0]    s_atvalid, s_atlast, port_en;
  logic [NP*DW-1:0] s_atdata;
  logic             m_atready, rr_mode, flush_req;

  logic [NP-1:0] a_ready, a_grant, b_ready, b_grant;
  logic [IW-1:0] a_id, b_id;
  logic [DW-1:0] a_data, b_data;
  logic          a_valid, a_last, a_fd, b_valid, b_last, b_fd;

  atb_funnel_n #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ATID_WIDTH(IW), .MAX_HOLD(16)) dut (
    .clk_i(clk), .rst_i(rst), .s_atid_i(s_atid), .s_atvalid_i(s_atvalid),
    .s_atdata_i(s_atdata), .s_atlast_i(s_atlast), .s_atready_o(a_ready),
    .m_atid_o(a_id), .m_atvalid_o(a_valid), .m_atdata_o(a_data), .m_atlast_o(a_last),
    .m_atready_i(m_atready), .port_en_i(port_en), .rr_mode_i(rr_mode),
    .flush_req_i(flush_req), .flush_done_o(a_fd), .grant_o(a_grant));

  atb_funnel_n #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ATID_WIDTH(IW), .MAX_HOLD(4)) dut_h4 (
    .clk_i(clk), .rst_i(rst), .s_atid_i(s_atid), .s_atvalid_i(s_atvalid),
    .s_atdata_i(s_atdata), .s_atlast_i(s_atlast), .s_atready_o(b_ready),
    .m_atid_o(b_id), .m_atvalid_o(b_valid), .m_atdata_o(b_data), .m_atlast_o(b_last),
    .m_atready_i(m_atready), .port_en_i(port_en), .rr_mode_i(rr_mode),
    .flush_req_i(flush_req), .flush_done_o(b_fd), .grant_o(b_grant));

  // The source model and monitor follow whichever instance is under test.
  logic          use_b = 1'b0;
  logic [NP-1:0] v_ready, v_grant;
  logic [IW-1:0] v_id;
  logic [DW-1:0] v_data;
  logic          v_valid, v_last, v_fd;
  assign v_ready = use_b ? b_ready : a_ready;
  assign v_grant = use_b ? b_grant : a_grant;
  assign v_id    = use_b ? b_id    : a_id;
  assign v_data  = use_b ? b_data  : a_data;
  assign v_valid = use_b ? b_valid : a_valid;
  assign v_last  = use_b ? b_last  : a_last;
  assign v_fd    = use_b ? b_fd    : a_fd;

  typedef struct {
    int            cyc;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          last;
  } beat_rec_t;

  typedef struct {
    int cyc;
    int port;
  } grant_rec_t;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          l;
    logic [NP-1:0] e_grant;
    logic          e_rdy;
    logic          e_mv;
    logic [DW-1:0] e_md;
    logic          e_ml;
  } vec_t;

  logic [DW-1:0] qd [NP][$];
  logic          ql [NP][$];
  beat_rec_t     out_log[$];
  beat_rec_t     exp_log[$];
  grant_rec_t    gnt_log[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc_n = 0;
  int acc_total = 0;
  int out_total = 0;
  logic [NP-1:0] acc_s, smp_ready, smp_grant, prev_grant;
  logic          smp_mv, smp_fd;

  function automatic logic [DW-1:0] mk_data(input int p, input int s);
    return {8'(p), 56'(s)};
  endfunction

  function automatic logic [IW-1:0] id_of(input int p);
    return IW'(16 + p);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      s_atid[p*IW +: IW] = id_of(p);
      if (qd[p].size() > 0) begin
        s_atvalid[p]         = 1'b1;
        s_atdata[p*DW +: DW] = qd[p][0];
        s_atlast[p]          = ql[p][0];
      end else begin
        s_atvalid[p]         = 1'b0;
        s_atdata[p*DW +: DW] = '0;
        s_atlast[p]          = 1'b0;
      end
    end
  endtask

  // One clock: sample on the falling edge, then retire accepted beats after the rising edge.
  task automatic cyc();
    @(negedge clk);
    smp_ready = v_ready;
    smp_grant = v_grant;
    smp_mv    = v_valid;
    smp_fd    = v_fd;
    acc_s     = s_atvalid & v_ready;
    for (int p = 0; p < NP; p++) if (acc_s[p]) acc_total++;
    if (v_valid && m_atready) begin
      out_log.push_back('{cyc_n, v_id, v_data, v_last});
      out_total++;
    end
    if (v_grant != '0 && prev_grant == '0) begin
      for (int p = 0; p < NP; p++) if (v_grant[p]) gnt_log.push_back('{cyc_n, p});
    end
    prev_grant = v_grant;
    @(posedge clk);
    #1;
    cyc_n++;
    for (int p = 0; p < NP; p++) begin
      if (acc_s[p]) begin
        void'(qd[p].pop_front());
        void'(ql[p].pop_front());
      end
    end
    drive();
  endtask

  task automatic enq(input int p, input int n);
    for (int s = 0; s < n; s++) begin
      qd[p].push_back(mk_data(p, s));
      ql[p].push_back(s == n - 1);
    end
  endtask

  task automatic exp_add(input int p, input int first, input int n, input int total);
    for (int s = first; s < first + n; s++)
      exp_log.push_back('{0, id_of(p), mk_data(p, s), (s == total - 1)});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int p = 0; p < NP; p++) begin
      qd[p].delete();
      ql[p].delete();
    end
    out_log.delete();
    exp_log.delete();
    gnt_log.delete();
    port_en    = '1;
    rr_mode    = 1'b0;
    flush_req  = 1'b0;
    m_atready  = 1'b1;
    prev_grant = '0;
    acc_total  = 0;
    out_total  = 0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    cyc_n = 0;
  endtask

  function automatic bit busy();
    bit b;
    b = v_valid || (v_grant != '0);
    for (int p = 0; p < NP; p++) if (qd[p].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while (busy() && k < budget) begin
      cyc();
      k++;
    end
    chk({tag, "_timeout"}, 64'(k >= budget), 64'd0);
    repeat (2) cyc();
  endtask

  task automatic chk_stream(input string tag);
    int n;
    chk({tag, "_beats"}, 64'(out_log.size()), 64'(exp_log.size()));
    n = (out_log.size() < exp_log.size()) ? out_log.size() : exp_log.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_data"}, out_log[i].data, exp_log[i].data);
      chk({tag, "_id_last"}, 64'({out_log[i].id, out_log[i].last}),
          64'({exp_log[i].id, exp_log[i].last}));
    end
  endtask

  task automatic chk_grant(input string tag, input int idx, input int port, input int at);
    if (gnt_log.size() > idx) begin
      chk({tag, "_port"}, 64'(gnt_log[idx].port), 64'(port));
      chk({tag, "_cycle"}, 64'(gnt_log[idx].cyc), 64'(at));
    end else begin
      chk({tag, "_missing"}, 64'(gnt_log.size()), 64'(idx + 1));
    end
  endtask

  vec_t tv[8];

  initial begin
    // Port 2, five beats, ID 0x12: grant at 1, outputs at 2..6, idle again at 6.
    tv[0] = '{1'b1, mk_data(2, 0), 1'b0, 6'b000000, 1'b0, 1'b0, '0, 1'b0};
    tv[1] = '{1'b1, mk_data(2, 0), 1'b0, 6'b000100, 1'b1, 1'b0, '0, 1'b0};
    tv[2] = '{1'b1, mk_data(2, 1), 1'b0, 6'b000100, 1'b1, 1'b1, mk_data(2, 0), 1'b0};
    tv[3] = '{1'b1, mk_data(2, 2), 1'b0, 6'b000100, 1'b1, 1'b1, mk_data(2, 1), 1'b0};
    tv[4] = '{1'b1, mk_data(2, 3), 1'b0, 6'b000100, 1'b1, 1'b1, mk_data(2, 2), 1'b0};
    tv[5] = '{1'b1, mk_data(2, 4), 1'b1, 6'b000100, 1'b1, 1'b1, mk_data(2, 3), 1'b0};
    tv[6] = '{1'b0, '0,            1'b0, 6'b000000, 1'b0, 1'b1, mk_data(2, 4), 1'b1};
    tv[7] = '{1'b0, '0,            1'b0, 6'b000000, 1'b0, 1'b0, '0, 1'b0};

    s_atid = '0; s_atvalid = '0; s_atdata = '0; s_atlast = '0;
    port_en = '1; rr_mode = 1'b0; flush_req = 1'b0; m_atready = 1'b1;

    // Reset state of both instances.
    #2;
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    chk("rst_a_grant", 64'(a_grant), 64'd0);
    chk("rst_a_out", 64'({a_valid, a_last, a_fd, a_id}), 64'd0);
    chk("rst_a_data", a_data, 64'd0);
    chk("rst_b_state", 64'({b_ready, b_grant, b_valid, b_last, b_fd}), 64'd0);

    // Single-port stream, table-driven.
    do_reset();
    for (int r = 0; r < 8; r++) begin
      s_atvalid[2]         = tv[r].v;
      s_atdata[2*DW +: DW] = tv[r].d;
      s_atlast[2]          = tv[r].l;
      @(negedge clk);
      chk("t1_grant", 64'(a_grant), 64'(tv[r].e_grant));
      chk("t1_ready", 64'(a_ready[2]), 64'(tv[r].e_rdy));
      chk("t1_mvalid", 64'(a_valid), 64'(tv[r].e_mv));
      if (tv[r].e_mv) begin
        chk("t1_mdata", a_data, tv[r].e_md);
        chk("t1_mid_last", 64'({a_id, a_last}), 64'({8'h12, tv[r].e_ml}));
      end
      @(posedge clk);
      #1;
    end

    // Fixed-priority contention: 1, 3, 4 with one ARB cycle between grants.
    do_reset();
    enq(1, 2); enq(3, 2); enq(4, 2);
    drive();
    drain("t2", 60);
    chk_grant("t2_g0", 0, 1, 1);
    chk_grant("t2_g1", 1, 3, 4);
    chk_grant("t2_g2", 2, 4, 7);
    exp_add(1, 0, 2, 2); exp_add(3, 0, 2, 2); exp_add(4, 0, 2, 2);
    chk_stream("t2");

    // Round robin, all ports busy.
    do_reset();
    rr_mode = 1'b1;
    for (int p = 0; p < NP; p++) begin
      enq(p, 1); enq(p, 1);
    end
    drive();
    drain("t3", 80);
    for (int i = 0; i < 7; i++) begin
      if (gnt_log.size() > i) chk("t3_rr_order", 64'(gnt_log[i].port), 64'(i % NP));
      else chk("t3_rr_missing", 64'(gnt_log.size()), 64'(i + 1));
    end

    // Hold limit of 4 beats: port 0 long packet, port 1 pending.
    use_b = 1'b1;
    do_reset();
    rr_mode = 1'b1;
    enq(0, 10); enq(1, 2);
    drive();
    drain("t4", 100);
    chk_grant("t4_g0", 0, 0, 1);
    chk_grant("t4_g1", 1, 1, 6);
    chk_grant("t4_g2", 2, 0, 9);
    chk_grant("t4_g3", 3, 0, 14);
    exp_add(0, 0, 4, 10); exp_add(1, 0, 2, 2); exp_add(0, 4, 4, 10); exp_add(0, 8, 2, 10);
    chk_stream("t4");
    use_b = 1'b0;

    // Backpressure for 5 cycles mid-packet.
    do_reset();
    enq(2, 8);
    drive();
    repeat (3) cyc();
    m_atready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      cyc();
      if (j >= 1) chk("t5_ready_low", 64'(smp_ready[2]), 64'd0);
      chk("t5_valid_held", 64'(smp_mv), 64'd1);
    end
    chk("t5_buffered", 64'(acc_total - out_total), 64'd2);
    m_atready = 1'b1;
    drain("t5", 60);
    exp_add(2, 0, 8, 8);
    chk_stream("t5");

    // Flush while the owner is disabled mid-packet.
    do_reset();
    flush_req = 1'b1;
    enq(0, 6);
    drive();
    repeat (3) cyc();
    port_en = 6'b111110;
    cyc();
    chk("t6_grant_c3", 64'(smp_grant), 64'b000001);
    chk("t6_ready_c3", 64'(smp_ready), 64'd0);
    cyc();
    chk("t6_grant_c4", 64'(smp_grant), 64'd0);
    chk("t6_fd_c4", 64'(smp_fd), 64'd0);
    cyc();
    chk("t6_fd_c5", 64'(smp_fd), 64'd1);
    flush_req = 1'b0;
    cyc();
    chk("t6_fd_c6", 64'(smp_fd), 64'd1);
    cyc();
    chk("t6_fd_c7", 64'(smp_fd), 64'd0);
    exp_add(0, 0, 2, 6);
    chk_stream("t6");

    // Asynchronous reset in the middle of a packet.
    do_reset();
    enq(2, 8);
    drive();
    repeat (4) cyc();
    chk("t7_pre_valid", 64'(a_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("t7_rst_ctrl", 64'({a_ready, a_grant, a_valid, a_last, a_fd}), 64'd0);
    chk("t7_rst_id", 64'(a_id), 64'd0);
    chk("t7_rst_data", a_data, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
